// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master AXI read-channel arbiter (m0 = IFU, m1 = LSU)
// One AR is accepted, forwarded, and its R burst routed back before the bus is released.
module axi_rd_arbiter #(
  parameter int LSU_PRIO = 1,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  input  logic [42:0] m0_ar,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic [34:0] m0_r,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  input  logic [42:0] m1_ar,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [34:0] m1_r,
  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [42:0] s_ar,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [34:0] s_r,
  output logic [1:0]  grant,
  output logic        protocol_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, target;
  logic             last_lsu;
  logic             pick0, pick1;
  logic             beat, cnt_hit, burst_done;

  // On a tie the LSU wins outright, or the master not served last wins.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (m0_arvalid && m1_arvalid) begin
      if (LSU_PRIO != 0 || !last_lsu) pick1 = 1'b1;
      else                            pick0 = 1'b1;
    end else begin
      pick0 = m0_arvalid;
      pick1 = m1_arvalid;
    end
  end

  assign beat       = (state == DATA) && s_rvalid && s_rready;
  assign cnt_hit    = (cnt == target);
  assign burst_done = beat && cnt_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick0 || pick1) state_nxt = ADDR;
      ADDR:    if (s_arready)      state_nxt = DATA;
      DATA:    if (burst_done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // arready is gated by reset so nothing handshakes while reset is held.
  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_r       = '0;
    m1_r       = '0;
    s_rready   = 1'b0;
    s_arvalid  = (state == ADDR);
    case (state)
      IDLE: begin
        m0_arready = pick0 && reset;
        m1_arready = pick1 && reset;
      end
      DATA: begin
        if (grant[0]) begin
          m0_rvalid = s_rvalid;
          m0_r      = s_r;
          s_rready  = m0_rready;
        end else if (grant[1]) begin
          m1_rvalid = s_rvalid;
          m1_r      = s_r;
          s_rready  = m1_rready;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ar         <= '0;
      target       <= '0;
      cnt          <= '0;
      grant        <= 2'b00;
      last_lsu     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (state == IDLE && (pick0 || pick1)) begin
        s_ar     <= pick1 ? m1_ar : m0_ar;
        target   <= CNT_W'(pick1 ? m1_ar[10:3] : m0_ar[10:3]);
        grant    <= {pick1, pick0};
        last_lsu <= pick1;
        cnt      <= '0;
      end
      if (beat) begin
        // The burst ends on the count; rlast is only cross-checked.
        if (s_r[0] != cnt_hit) protocol_err <= 1'b1;
        if (cnt_hit) begin
          cnt   <= '0;
          grant <= 2'b00;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized scoreboard bench for axi_rd_arbiter
// Lane 0 runs LSU_PRIO=1, lane 1 runs LSU_PRIO=0.
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lanes_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int PRIO = (g == 0) ? 1 : 0;

    logic        rst_n;
    logic        mv[2], mardy[2], mrv[2], mrr[2];
    logic [42:0] mar[2];
    logic [34:0] mr[2];
    logic        s_arvalid, s_arready, s_rvalid, s_rready, perr;
    logic [42:0] s_ar;
    logic [34:0] s_r;
    logic [1:0]  grant;

    axi_rd_arbiter #(.LSU_PRIO(PRIO), .CNT_W(8)) dut (
      .clk(clk), .reset(rst_n),
      .m0_arvalid(mv[0]), .m0_arready(mardy[0]), .m0_ar(mar[0]),
      .m0_rvalid(mrv[0]), .m0_rready(mrr[0]), .m0_r(mr[0]),
      .m1_arvalid(mv[1]), .m1_arready(mardy[1]), .m1_ar(mar[1]),
      .m1_rvalid(mrv[1]), .m1_rready(mrr[1]), .m1_r(mr[1]),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
      .grant(grant), .protocol_err(perr)
    );

    // Reference model: bus owner, phase (0 free, 1 address, 2 data), beats seen vs arlen.
    int own = -1, oi = 0, phase = 0, last = 0, cnt = 0, tgt = 0, bursts = 0, w = -1, rst_hold = 0;
    bit exp_err = 0, beat_taken = 0, real_on = 0, rst_done = 0, stop = 0;
    bit ar_taken[2];
    logic [8:0]  ctl_exp, ctl_act;
    logic [34:0] bt, got;
    logic [42:0] ea;
    logic [42:0] exp_ar[$];
    logic [34:0] er0[$], er1[$], sq[$];

    // Monitor: compares DUT outputs with the model, then advances the model.
    always @(negedge clk) begin
      if (rst_n) begin
        ar_taken[0] = mardy[0] && mv[0];
        ar_taken[1] = mardy[1] && mv[1];
        beat_taken  = s_rvalid && s_rready;
        oi = (own < 0) ? 0 : own;
        w = -1;
        if (phase == 0) begin
          if (mv[0] && mv[1]) w = (PRIO == 1 || last == 0) ? 1 : 0;
          else if (mv[0])     w = 0;
          else if (mv[1])     w = 1;
        end
        ctl_exp = {(own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10),
                   phase == 1, phase == 2 && mrr[oi], w == 0, w == 1,
                   phase == 2 && own == 0 && s_rvalid, phase == 2 && own == 1 && s_rvalid};
        ctl_act = {grant, s_arvalid, s_rready, mardy[0], mardy[1], mrv[0], mrv[1]};
        chk($sformatf("L%0d.ctl", g), 64'(ctl_act), 64'(ctl_exp));
        for (int i = 0; i < 2; i++)
          chk($sformatf("L%0d.r_route%0d", g, i), 64'(mr[i]),
              (phase == 2 && own == i) ? 64'(s_r) : 64'd0);
        chk($sformatf("L%0d.protocol_err", g), 64'(perr), 64'(exp_err));
        for (int i = 0; i < 2; i++) begin
          if (mrv[i] && mrr[i]) begin
            if ((i == 0 ? er0.size() : er1.size()) == 0) begin
              chk($sformatf("L%0d.r_extra%0d", g, i), 64'(mr[i]), 64'h1_0000_0000_0);
            end else begin
              bt = (i == 0) ? er0.pop_front() : er1.pop_front();
              chk($sformatf("L%0d.r_beat%0d", g, i), 64'(mr[i]), 64'(bt));
            end
          end
        end
        case (phase)
          0: if (w >= 0) begin
            exp_ar.push_back(mar[w]);
            own = w; last = w; tgt = int'(mar[w][10:3]); cnt = 0; phase = 1;
          end
          1: if (s_arready) begin
            ea = exp_ar.pop_front();
            chk($sformatf("L%0d.s_ar", g), 64'(s_ar), 64'(ea));
            for (int k = 0; k <= tgt; k++) begin
              bt = {$urandom, 2'($urandom_range(0, 3)),
                    1'((k == tgt) ^ (bursts == 20 && k == 0))};
              sq.push_back(bt);
              if (own == 0) er0.push_back(bt); else er1.push_back(bt);
            end
            phase = 2;
          end
          default: if (s_rvalid && mrr[oi]) begin
            if (s_r[0] != (cnt == tgt)) exp_err = 1;
            if (cnt == tgt) begin
              phase = 0; own = -1; bursts++;
            end else begin
              cnt++;
            end
          end
        endcase
      end
    end

    // Masters, slave and reset injection are driven just after each rising edge.
    always @(posedge clk) begin
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) begin
          #2 rst_n = 1'b1;
        end
      end else if (rst_n && bursts == 30 && phase == 2 && !rst_done) begin
        #2 rst_n = 1'b0;
        #1;
        chk($sformatf("L%0d.rst_ctl", g),
            64'({grant, s_arvalid, s_rready, mardy[0], mardy[1], mrv[0], mrv[1]}), 64'd0);
        chk($sformatf("L%0d.rst_r", g), 64'({mr[0], mr[1]}), 64'd0);
        chk($sformatf("L%0d.rst_err", g), 64'(perr), 64'd0);
        own = -1; phase = 0; last = 0; cnt = 0; exp_err = 0; real_on = 0;
        exp_ar.delete(); er0.delete(); er1.delete(); sq.delete();
        ar_taken[0] = 0; ar_taken[1] = 0; beat_taken = 0;
        mv[0] = 0; mv[1] = 0; s_rvalid = 0;
        rst_done = 1; rst_hold = 2;
      end else if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (ar_taken[i]) mv[i] = 1'b0;
          ar_taken[i] = 1'b0;
          if (!mv[i] && !stop && $urandom_range(0, 1) == 0) begin
            mv[i]  = 1'b1;
            mar[i] = {$urandom,
                      8'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 15 : 3)),
                      3'($urandom_range(0, 2))};
          end
          mrr[i] = ($urandom_range(0, 3) != 0);
        end
        s_arready = ($urandom_range(0, 1) == 0);
        if (beat_taken && real_on) void'(sq.pop_front());
        if (sq.size() > 0 && ((real_on && !beat_taken) || $urandom_range(0, 3) != 0)) begin
          s_rvalid = 1'b1; s_r = sq[0]; real_on = 1;
        end else if (sq.size() == 0 && $urandom_range(0, 7) == 0) begin
          s_rvalid = 1'b1; s_r = 35'({$urandom, $urandom}); real_on = 0;
        end else begin
          s_rvalid = 1'b0; s_r = 35'({$urandom, $urandom}); real_on = 0;
        end
        beat_taken = 0;
      end
    end

    initial begin
      rst_n = 1'b0;
      mv[0] = 0; mv[1] = 0; mrr[0] = 0; mrr[1] = 0;
      mar[0] = '0; mar[1] = '0;
      ar_taken[0] = 0; ar_taken[1] = 0;
      s_arready = 0; s_rvalid = 0; s_r = '0;
      #2;
      chk($sformatf("L%0d.reset_ctl", g),
          64'({grant, s_arvalid, s_rready, mardy[0], mardy[1], mrv[0], mrv[1]}), 64'd0);
      chk($sformatf("L%0d.reset_s_ar", g), 64'(s_ar), 64'd0);
      chk($sformatf("L%0d.reset_err", g), 64'(perr), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int c = 0; c < 20000 && bursts < 40; c++) @(posedge clk);
      chk($sformatf("L%0d.bursts_done", g), 64'(bursts >= 40), 64'd1);
      chk($sformatf("L%0d.reset_injected", g), 64'(rst_done), 64'd1);
      stop = 1;
      repeat (30) @(posedge clk);
      lanes_done++;
    end
  end

  initial begin
    wait (lanes_done == 2);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-master, one-slave AXI read-channel arbiter that shares the single memory read port between IFU (master 0) and LSU/MEMU (master 1).
- Accepts one AR from the winning master, forwards it to the slave and routes the R beats back to that master.
- Releases the bus only after the last beat of the burst.
- Write channels bypass this block; the LSU already serialises its write against B before issuing new reads.

Parameters:
LSU_PRIO, 1, 1 = LSU always wins simultaneous requests; 0 = round-robin using the last granted master
CNT_W, 8, width of beat counter (covers arlen 0..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
m0_arvalid  in  1  IFU address valid
m0_arready  out  1  IFU address accepted
m0_ar  in  43  IFU {araddr[31:0], arlen[7:0], arsize[2:0]}
m0_rvalid  out  1  read beat valid to IFU
m0_rready  in  1  IFU ready for beat
m0_r  out  35  {rdata[31:0], rresp[1:0], rlast} to IFU
m1_arvalid  in  1  LSU address valid
m1_arready  out  1  LSU address accepted
m1_ar  in  43  LSU AR payload, same packing
m1_rvalid  out  1  read beat valid to LSU
m1_rready  in  1  LSU ready for beat
m1_r  out  35  R payload to LSU
s_arvalid  out  1  slave address valid
s_arready  in  1  slave address ready
s_ar  out  43  registered AR payload to slave
s_rvalid  in  1  slave beat valid
s_rready  out  1  ready to slave
s_r  in  35  slave R payload
grant  out  2  00 idle, 01 IFU owns bus, 10 LSU owns bus
protocol_err  out  1  sticky: rlast disagreed with beat count

Behaviour:
- Reset (reset=0, async): state=IDLE; s_arvalid=0, s_ar=0, m0/m1_arready=0, s_rready=0, m0/m1_rvalid=0, grant=00, beat counter=0, protocol_err=0. Last-grant pointer resets to IFU, so the first tie with LSU_PRIO=0 goes to LSU.
- States: IDLE, ADDR, DATA.
- IDLE:
  - The winner is chosen combinationally from m0_arvalid/m1_arvalid.
  - The winner's arready=1 for that cycle only; both arready=0 if no request.
  - On a handshake, latch the winner's payload into s_ar and arlen into the beat target, set grant, update the last-grant pointer, and go to ADDR.
  - The loser sees arready=0 and must hold its request.
- ADDR:
  - s_arvalid=1 with stable s_ar until s_arready=1, then go to DATA.
  - Minimum AR latency: master handshake at cycle N, s_arvalid first high at N+1.
- DATA:
  - Routing is combinational: granted m*_rvalid=s_rvalid, m*_r=s_r, s_rready=granted m*_rready. The non-granted rvalid=0 and its r=0.
  - On each s_rvalid&&s_rready beat the counter increments.
  - The burst ends on the beat where counter==arlen (i.e. the arlen+1-th beat). Next cycle: state=IDLE, grant=00, counter=0.
  - No master arready is asserted in the completion cycle, so there is one idle bubble between bursts.
- protocol_err is set (sticky until reset) on any beat where rlast != (counter==arlen). The transaction still ends on the count, not on rlast.
- s_rready=0 outside DATA; stray slave beats in IDLE/ADDR are not forwarded.
- rresp is passed through unmodified; the arbiter takes no action on error responses.
- Simultaneous requests:
  - LSU_PRIO=1: LSU wins.
  - LSU_PRIO=0: the master not granted last wins.
  - A single requester always wins immediately.
- A request arriving while busy waits; no preemption mid-burst.
- Reset asserted mid-burst drops all valids immediately. Outstanding slave beats are the slave's responsibility (the slave is reset together with the arbiter).

Test Plan:
- IFU only, araddr=0x3000_0000 arlen=0, slave ready next cycle, rdata=0xDEADBEEF rlast=1 -> m0_arready pulse, s_arvalid next cycle with s_ar matching, m0_r data 0xDEADBEEF, grant 01 then 00, m1_rvalid never 1.
- Both request same cycle, LSU_PRIO=1 -> LSU granted (grant=10); IFU waits; IFU served right after LSU burst completes plus one bubble.
- LSU_PRIO=0, both masters requesting continuously for 4 bursts -> grants alternate 10,01,10,01.
- IFU burst arlen=3 with s_rvalid gaps and m0_rready low for 2 cycles -> exactly 4 beats forwarded in order, s_rready mirrors m0_rready, bus freed after 4th beat.
- arlen=1 but slave asserts rlast on beat 1 -> protocol_err=1 and stays 1; transaction still ends after beat 2.
- Assert reset during DATA -> all valid/ready outputs 0 and grant=00 immediately, without waiting for a clock edge; new request after release served normally.
